// File: rtl/id_stage.sv
// RV32I instruction-decode stage: IF/ID register, decoder, 32x32 register
// file, branch/JAL redirect resolution and the registered ID/EX bundle.
module id_stage #(
    parameter bit RF_RESET_ZERO = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic        i_stall,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    output logic        o_btaken,
    output logic        o_jal,
    output logic [31:0] o_imm_i,
    output logic [31:0] o_imm_j,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rd,
    output logic [3:0]  o_alu_op,
    output logic        o_reg_we,
    output logic        o_mem_re,
    output logic        o_mem_we,
    output logic        o_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
    } if_id_t;

    if_id_t if_id;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;

    assign inst   = if_id.inst;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

    logic [31:0] imm_i_t;
    logic [31:0] imm_s_t;
    logic [31:0] imm_b_t;
    logic [31:0] imm_u_t;
    logic [31:0] imm_j_t;

    assign imm_i_t = {{20{inst[31]}}, inst[31:20]};
    assign imm_s_t = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b_t = {{19{inst[31]}}, inst[31], inst[7],
                      inst[30:25], inst[11:8], 1'b0};
    assign imm_u_t = {inst[31:12], 12'b0};
    assign imm_j_t = {{11{inst[31]}}, inst[31], inst[19:12],
                      inst[20], inst[30:21], 1'b0};

    assign o_imm_i = imm_b_t;
    assign o_imm_j = imm_j_t;

    logic        illegal;
    logic        is_branch;
    logic        is_jal;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [3:0]  alu_d;
    logic [31:0] imm_d;

    always_comb begin
        illegal   = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        reg_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        alu_d     = 4'b0;
        imm_d     = 32'b0;
        unique case (1'b1)
            (opcode == OPC_LUI),
            (opcode == OPC_AUIPC): begin
                reg_wr = 1'b1;
                imm_d  = imm_u_t;
            end
            (opcode == OPC_JAL): begin
                is_jal = 1'b1;
                reg_wr = 1'b1;
                imm_d  = imm_j_t;
            end
            (opcode == OPC_BRANCH): begin
                is_branch = 1'b1;
                imm_d     = imm_b_t;
                illegal   = (funct3[2:1] == 2'b01);
            end
            (opcode == OPC_LOAD): begin
                reg_wr = 1'b1;
                mem_rd = 1'b1;
                imm_d  = imm_i_t;
            end
            (opcode == OPC_STORE): begin
                mem_wr = 1'b1;
                imm_d  = imm_s_t;
            end
            (opcode == OPC_OPIMM): begin
                reg_wr = 1'b1;
                alu_d  = {inst[30], funct3};
                imm_d  = imm_i_t;
            end
            (opcode == OPC_OP): begin
                reg_wr = 1'b1;
                alu_d  = {inst[30], funct3};
            end
            default: illegal = 1'b1;
        endcase
        if (rd == 5'd0) begin
            reg_wr = 1'b0;
        end
    end

    // Entry 0 is never written, so it stays at its reset/initial value
    // and reads of x0 are masked to zero below anyway.
    logic [31:0] rf [32];
    logic        rf_wr;

    assign rf_wr = i_wb_we && (i_wb_rd != 5'd0);

    if (RF_RESET_ZERO) begin : g_rf_rst
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                for (int i = 0; i < 32; i++) begin
                    rf[i] <= 32'b0;
                end
            end else if (rf_wr) begin
                rf[i_wb_rd] <= i_wb_data;
            end
        end
    end else begin : g_rf_nrst
        always_ff @(posedge i_clk) begin
            if (rf_wr) begin
                rf[i_wb_rd] <= i_wb_data;
            end
        end
    end

    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    always_comb begin
        rs1_data = rf[rs1];
        rs2_data = rf[rs2];
        if (rf_wr && (i_wb_rd == rs1)) begin
            rs1_data = i_wb_data;
        end
        if (rf_wr && (i_wb_rd == rs2)) begin
            rs2_data = i_wb_data;
        end
        if (rs1 == 5'd0) begin
            rs1_data = 32'b0;
        end
        if (rs2 == 5'd0) begin
            rs2_data = 32'b0;
        end
    end

    logic eq;
    logic lt;
    logic ltu;
    logic cmp;

    assign eq  = (rs1_data == rs2_data);
    assign lt  = ($signed(rs1_data) < $signed(rs2_data));
    assign ltu = (rs1_data < rs2_data);

    always_comb begin
        cmp = 1'b0;
        unique case (funct3)
            3'b000:  cmp = eq;
            3'b001:  cmp = !eq;
            3'b100:  cmp = lt;
            3'b101:  cmp = !lt;
            3'b110:  cmp = ltu;
            3'b111:  cmp = !ltu;
            default: cmp = 1'b0;
        endcase
    end

    assign o_btaken = if_id.valid && is_branch && !illegal && cmp;
    assign o_jal    = if_id.valid && is_jal;

    logic redirect;
    assign redirect = o_btaken || o_jal;

    // A held redirect keeps asserting through a stall, so the squash
    // lands on the first edge that actually loads IF/ID.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            if_id <= '0;
        end else if (!i_stall) begin
            if_id.valid <= !redirect;
            if_id.inst  <= i_inst;
            if_id.pc    <= i_pc;
        end
    end

    logic ex_ok;
    assign ex_ok = if_id.valid && !i_stall && !illegal;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid    <= 1'b0;
            o_reg_we   <= 1'b0;
            o_mem_re   <= 1'b0;
            o_mem_we   <= 1'b0;
            o_illegal  <= 1'b0;
            o_pc       <= 32'b0;
            o_rs1_data <= 32'b0;
            o_rs2_data <= 32'b0;
            o_imm      <= 32'b0;
            o_rd       <= 5'b0;
            o_alu_op   <= 4'b0;
        end else begin
            o_valid    <= ex_ok;
            o_reg_we   <= ex_ok && reg_wr;
            o_mem_re   <= ex_ok && mem_rd;
            o_mem_we   <= ex_ok && mem_wr;
            o_illegal  <= if_id.valid && !i_stall && illegal;
            o_pc       <= if_id.pc;
            o_rs1_data <= rs1_data;
            o_rs2_data <= rs2_data;
            o_imm      <= imm_d;
            o_rd       <= rd;
            o_alu_op   <= alu_d;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: vector table with an EX-side scoreboard queue plus
// hand-written reset, bypass, x0, stall and squash sequences.
module tb_id_stage;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [31:0] i_inst;
    logic [31:0] i_pc;
    logic        i_stall;
    logic        i_wb_we;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic        o_btaken;
    logic        o_jal;
    logic [31:0] o_imm_i;
    logic [31:0] o_imm_j;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;
    logic [31:0] o_imm;
    logic [4:0]  o_rd;
    logic [3:0]  o_alu_op;
    logic        o_reg_we;
    logic        o_mem_re;
    logic        o_mem_we;
    logic        o_illegal;

    int checks = 0;
    int failures = 0;

    id_stage #(.RF_RESET_ZERO(1'b1)) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_inst     (i_inst),
        .i_pc       (i_pc),
        .i_stall    (i_stall),
        .i_wb_we    (i_wb_we),
        .i_wb_rd    (i_wb_rd),
        .i_wb_data  (i_wb_data),
        .o_btaken   (o_btaken),
        .o_jal      (o_jal),
        .o_imm_i    (o_imm_i),
        .o_imm_j    (o_imm_j),
        .o_valid    (o_valid),
        .o_pc       (o_pc),
        .o_rs1_data (o_rs1_data),
        .o_rs2_data (o_rs2_data),
        .o_imm      (o_imm),
        .o_rd       (o_rd),
        .o_alu_op   (o_alu_op),
        .o_reg_we   (o_reg_we),
        .o_mem_re   (o_mem_re),
        .o_mem_we   (o_mem_we),
        .o_illegal  (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        bt;
        logic        jal;
        int          kind;
        logic [31:0] idimm;
        logic        v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        we;
        logic        re;
        logic        me;
        logic        ill;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd,
                                          logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2,
                                          logic [4:0] rs1, logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(logic [12:0] off, logic [4:0] rs2,
                                          logic [4:0] rs1, logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11],
                7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(logic [19:0] u, logic [4:0] rd,
                                          logic [6:0] op);
        return {u, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(logic [20:0] off, logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2,
                                          logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic addv(input logic [31:0] inst, input logic bt,
                        input logic jal, input int kind,
                        input logic [31:0] idimm, input logic v,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [3:0] alu, input logic we,
                        input logic re, input logic me, input logic ill,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        vec_t e;
        e.inst = inst; e.pc = 32'h1000 + 32'(vecs.size() * 4);
        e.bt = bt; e.jal = jal; e.kind = kind; e.idimm = idimm;
        e.v = v; e.imm = imm; e.rd = rd; e.alu = alu;
        e.we = we; e.re = re; e.me = me; e.ill = ill;
        e.rs1 = rs1; e.rs2 = rs2;
        vecs.push_back(e);
    endtask

    task automatic squashed(input logic [31:0] inst);
        addv(inst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_ex(input vec_t e, input int k);
        chk($sformatf("v%0d.valid", k), 32'(o_valid), 32'(e.v));
        chk($sformatf("v%0d.illegal", k), 32'(o_illegal), 32'(e.ill));
        chk($sformatf("v%0d.reg_we", k), 32'(o_reg_we), 32'(e.we));
        chk($sformatf("v%0d.mem_re", k), 32'(o_mem_re), 32'(e.re));
        chk($sformatf("v%0d.mem_we", k), 32'(o_mem_we), 32'(e.me));
        if (e.v) begin
            chk($sformatf("v%0d.pc", k), o_pc, e.pc);
            chk($sformatf("v%0d.imm", k), o_imm, e.imm);
            chk($sformatf("v%0d.rd", k), 32'(o_rd), 32'(e.rd));
            chk($sformatf("v%0d.alu", k), 32'(o_alu_op), 32'(e.alu));
            chk($sformatf("v%0d.rs1", k), o_rs1_data, e.rs1);
            chk($sformatf("v%0d.rs2", k), o_rs2_data, e.rs2);
        end
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        i_wb_we = 1'b1; i_wb_rd = rd; i_wb_data = d;
        tick();
        i_wb_we = 1'b0;
    endtask

    initial begin
        vec_t e;
        int   ex_k;
        logic [31:0] beq8;

        beq8 = enc_b(13'd8, 5'd0, 5'd0, 3'b000);
        i_rstn = 1'b0; i_inst = beq8; i_pc = 32'h40; i_stall = 1'b0;
        i_wb_we = 1'b0; i_wb_rd = 5'd0; i_wb_data = 32'b0;

        // Reset: everything quiet while held.
        tick(); tick();
        chk("rst.btaken", 32'(o_btaken), 0);
        chk("rst.jal", 32'(o_jal), 0);
        chk("rst.imm_i", o_imm_i, 0);
        chk("rst.imm_j", o_imm_j, 0);
        chk("rst.valid", 32'(o_valid), 0);
        chk("rst.illegal", 32'(o_illegal), 0);
        chk("rst.pc", o_pc, 0);
        chk("rst.imm", o_imm, 0);
        i_rstn = 1'b1;
        tick();
        chk("rel.btaken", 32'(o_btaken), 1);
        chk("rel.imm_i", o_imm_i, 32'h8);
        i_inst = NOP; i_pc = 32'h48;
        tick();
        chk("rel.ex_valid", 32'(o_valid), 1);
        chk("rel.ex_pc", o_pc, 32'h40);
        chk("rel.btaken_off", 32'(o_btaken), 0);
        tick();
        chk("rel.bubble", 32'(o_valid), 0);

        wb(5'd1, 32'hFFFF_FFFF);
        wb(5'd2, 32'h1);
        wb(5'd6, 32'h1234);

        addv(enc_i(12'd5, 5'd1, 3'b000, 5'd3, 7'h13), 0, 0, 0, 0,
             1, 5, 3, 0, 1, 0, 0, 0, 32'hFFFF_FFFF, 0);
        addv(enc_r(7'h20, 5'd2, 5'd6, 3'b000, 5'd4), 0, 0, 0, 0,
             1, 0, 4, 4'b1000, 1, 0, 0, 0, 32'h1234, 1);
        addv(enc_b(13'd8, 5'd2, 5'd1, 3'b100), 1, 0, 1, 8,
             1, 8, 8, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1);
        squashed(enc_i(12'd1, 5'd0, 3'b000, 5'd3, 7'h13));
        addv(enc_b(13'd8, 5'd2, 5'd1, 3'b110), 0, 0, 1, 8,
             1, 8, 8, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1);
        addv(enc_b(13'h1FFC, 5'd1, 5'd1, 3'b001), 0, 0, 1, 32'hFFFF_FFFC,
             1, 32'hFFFF_FFFC, 29, 0, 0, 0, 0, 0,
             32'hFFFF_FFFF, 32'hFFFF_FFFF);
        addv(enc_b(13'd16, 5'd2, 5'd1, 3'b101), 0, 0, 1, 16,
             1, 16, 16, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1);
        addv(enc_b(13'd16, 5'd2, 5'd1, 3'b111), 1, 0, 1, 16,
             1, 16, 16, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1);
        squashed(enc_i(12'd4, 5'd2, 3'b010, 5'd7, 7'h03));
        addv(enc_i(12'd4, 5'd2, 3'b010, 5'd7, 7'h03), 0, 0, 0, 0,
             1, 4, 7, 0, 1, 1, 0, 0, 1, 0);
        addv(enc_s(12'hFF8, 5'd6, 5'd2, 3'b010), 0, 0, 0, 0,
             1, 32'hFFFF_FFF8, 24, 0, 0, 0, 1, 0, 1, 32'h1234);
        addv(enc_u(20'hABCDE, 5'd8, 7'h37), 0, 0, 0, 0,
             1, 32'hABCD_E000, 8, 0, 1, 0, 0, 0, 0, 0);
        addv(enc_u(20'h1, 5'd9, 7'h17), 0, 0, 0, 0,
             1, 32'h1000, 9, 0, 1, 0, 0, 0, 0, 0);
        addv(enc_i(12'd0, 5'd2, 3'b000, 5'd1, 7'h67), 0, 0, 0, 0,
             0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        addv(NOP, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addv(enc_j(21'h10, 5'd1), 0, 1, 2, 32'h10,
             1, 32'h10, 1, 0, 1, 0, 0, 0, 0, 0);
        squashed(enc_i(12'd5, 5'd1, 3'b000, 5'd3, 7'h13));
        addv(enc_i(12'h0F0, 5'd6, 3'b111, 5'd10, 7'h13), 0, 0, 0, 0,
             1, 32'hF0, 10, 4'b0111, 1, 0, 0, 0, 32'h1234, 0);
        addv(enc_b(13'd8, 5'd2, 5'd1, 3'b010), 0, 0, 1, 8,
             0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        addv(enc_i(12'h403, 5'd1, 3'b101, 5'd11, 7'h13), 0, 0, 0, 0,
             1, 32'h403, 11, 4'b1101, 1, 0, 0, 0, 32'hFFFF_FFFF, 0);

        ex_k = 0;
        for (int k = 0; k < vecs.size(); k++) begin
            i_inst = vecs[k].inst;
            i_pc   = vecs[k].pc;
            sb.push_back(vecs[k]);
            tick();
            chk($sformatf("v%0d.btaken", k), 32'(o_btaken), 32'(vecs[k].bt));
            chk($sformatf("v%0d.jal", k), 32'(o_jal), 32'(vecs[k].jal));
            if (vecs[k].kind == 1)
                chk($sformatf("v%0d.imm_i", k), o_imm_i, vecs[k].idimm);
            if (vecs[k].kind == 2)
                chk($sformatf("v%0d.imm_j", k), o_imm_j, vecs[k].idimm);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                chk_ex(e, ex_k);
                ex_k++;
            end
        end
        i_inst = NOP; i_pc = 32'h2000;
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk_ex(e, ex_k);
            ex_k++;
        end

        // Writeback bypass into branch compare and operand.
        i_inst = enc_b(13'd8, 5'd6, 5'd5, 3'b000); i_pc = 32'h3000;
        tick();
        chk("byp.no_wb", 32'(o_btaken), 0);
        i_wb_we = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'h1234;
        #1;
        chk("byp.btaken", 32'(o_btaken), 1);
        i_inst = NOP; i_pc = 32'h3004;
        tick();
        i_wb_we = 1'b0;
        chk("byp.ex_valid", 32'(o_valid), 1);
        chk("byp.ex_rs1", o_rs1_data, 32'h1234);
        tick();
        chk("byp.bubble", 32'(o_valid), 0);

        // Writes to x0 are dropped and never bypassed.
        i_wb_we = 1'b1; i_wb_rd = 5'd0; i_wb_data = 32'hDEAD;
        i_inst = enc_r(7'h0, 5'd0, 5'd0, 3'b000, 5'd3); i_pc = 32'h3100;
        tick();
        i_inst = NOP; i_pc = 32'h3104;
        tick();
        i_wb_we = 1'b0;
        chk("x0.valid", 32'(o_valid), 1);
        chk("x0.rs1", o_rs1_data, 0);
        chk("x0.rs2", o_rs2_data, 0);

        // Stall for 3 cycles with a taken branch held in IF/ID.
        i_inst = enc_b(13'd12, 5'd0, 5'd0, 3'b000); i_pc = 32'h200;
        tick();
        chk("stl.btaken0", 32'(o_btaken), 1);
        i_stall = 1'b1;
        i_inst = enc_b(13'd20, 5'd0, 5'd0, 3'b000); i_pc = 32'h300;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stl%0d.valid", c), 32'(o_valid), 0);
            chk($sformatf("stl%0d.btaken", c), 32'(o_btaken), 1);
            chk($sformatf("stl%0d.imm_i", c), o_imm_i, 32'd12);
        end
        i_stall = 1'b0;
        i_inst = enc_i(12'd1, 5'd0, 3'b000, 5'd3, 7'h13); i_pc = 32'h400;
        tick();
        chk("stl.ex_valid", 32'(o_valid), 1);
        chk("stl.ex_pc", o_pc, 32'h200);
        chk("stl.btaken_off", 32'(o_btaken), 0);
        i_inst = NOP; i_pc = 32'h404;
        tick();
        chk("stl.squash", 32'(o_valid), 0);
        tick();
        chk("stl.next_valid", 32'(o_valid), 1);
        chk("stl.next_pc", o_pc, 32'h404);

        // Reset mid-operation with a taken branch in IF/ID.
        i_inst = beq8; i_pc = 32'h500;
        tick();
        chk("mrst.pre", 32'(o_btaken), 1);
        i_rstn = 1'b0;
        #1;
        chk("mrst.btaken", 32'(o_btaken), 0);
        chk("mrst.valid", 32'(o_valid), 0);
        chk("mrst.imm_i", o_imm_i, 0);
        i_inst = enc_r(7'h0, 5'd2, 5'd1, 3'b000, 5'd3); i_pc = 32'h600;
        tick();
        i_rstn = 1'b1;
        chk("mrst.held", 32'(o_btaken), 0);
        tick();
        chk("mrst.no_redir", 32'(o_btaken), 0);
        chk("mrst.ex_bubble", 32'(o_valid), 0);
        i_inst = NOP; i_pc = 32'h604;
        tick();
        chk("mrst.ex_valid", 32'(o_valid), 1);
        chk("mrst.rf_rs1", o_rs1_data, 0);
        chk("mrst.rf_rs2", o_rs2_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the RISC-V RV32I pipeline: the consumer end of the instruction-fetch interface. Latches the fetched instruction and PC into the IF/ID register and decodes it. Resolves conditional branches and JAL against an integrated 32x32 register file. Drives redirect controls back to fetch and presents registered operands and controls to execute.

## Interface
- RF_RESET_ZERO, 1: 1 = all 31 architectural registers clear to 0 on reset; 0 = register contents are not reset.
- i_clk  in  1  clock, all state on rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_inst  in  32  instruction from fetch (fetch o_inst)
- i_pc  in  32  PC of i_inst
- i_stall  in  1  execute back-pressure: hold IF/ID, bubble into EX
- i_wb_we  in  1  writeback enable
- i_wb_rd  in  5  writeback register index
- i_wb_data  in  32  writeback data
- o_btaken  out  1  conditional branch taken (to fetch i_btaken)
- o_jal  out  1  JAL in decode (to fetch i_jal)
- o_imm_i  out  32  sign-extended B-type offset (to fetch i_imm_i)
- o_imm_j  out  32  sign-extended J-type offset (to fetch i_imm_j)
- o_valid  out  1  EX-side instruction valid
- o_pc  out  32  EX-side PC
- o_rs1_data, o_rs2_data  out  32 each  EX-side operands
- o_imm  out  32  EX-side immediate (I/S/U/B/J per opcode)
- o_rd  out  5  destination register
- o_alu_op  out  4  {funct7[5], funct3} for OP/OP-IMM; 0000 otherwise
- o_reg_we, o_mem_re, o_mem_we  out  1 each  EX-side controls
- o_illegal  out  1  one-cycle pulse: unsupported opcode decoded

## Operation
- IF/ID register: {valid, inst, pc}. Loads every edge unless i_stall. Valid loads 1 except when squashed.
- Squash: if o_btaken or o_jal is high at an edge, the instruction loaded on that edge is the wrong-path fetch. IF/ID valid loads 0 for it; exactly one bubble per redirect.
- Redirect outputs are combinational from IF/ID contents and the register-file read. They are forced 0 when IF/ID valid is 0.
- o_imm_i / o_imm_j always reflect the current IF/ID instruction's B/J fields, regardless of opcode.
- Branch opcode 1100011, funct3 compare:
  - 000 BEQ, 001 BNE
  - 100 BLT, 101 BGE (signed)
  - 110 BLTU, 111 BGEU (unsigned)
  - 010/011 are illegal.
- Supported opcodes: LUI, AUIPC, JAL, BRANCH, LOAD, STORE, OP-IMM, OP. JALR and all others are illegal: o_illegal pulses and a bubble goes to EX.
- Register file:
  - 2 async read ports, 1 sync write port; x0 reads 0, writes to x0 ignored.
  - Read-during-write to the same nonzero index returns i_wb_data (bypass).
- EX register: loads decoded fields on every edge. When i_stall, IF/ID invalid, or illegal: o_valid, o_reg_we, o_mem_re, o_mem_we load 0; data fields don't-care.
- o_reg_we = 1 for LUI, AUIPC, JAL, LOAD, OP-IMM, OP with rd != 0.

## Timing
- Reset: every output and IF/ID valid go to 0 immediately, with all data outputs 0. Register file cleared when RF_RESET_ZERO = 1. The first fetch after release is accepted on the first edge.
- Decode-to-redirect: combinational, in the cycle the instruction sits in IF/ID.
- Decode-to-EX latency: 1 cycle.
- Stall concurrent with redirect: redirect outputs still assert; IF/ID holds; squash applies to the first edge without stall.
- Writeback and decode read of the same register in one cycle: bypassed value is used for branch compare and operands.
- Reset asserted mid-operation: in-flight IF/ID and EX contents are discarded; no redirect asserts until a new valid instruction is latched.

## Test plan
- Reset: rstn=0 with i_inst=BEQ x0,x0 -> all outputs 0; after release plus 1 edge, o_btaken=1 and o_imm_i matches the encoded offset (e.g. 0x00000008).
- Branch compare: x1=0xFFFFFFFF, x2=1 -> BLT x1,x2 taken; BLTU x1,x2 not taken; BNE x1,x1 not taken.
- Squash: JAL x1,+0x10 followed by ADDI -> o_jal=1 and o_imm_j=0x10; ADDI never reaches o_valid=1; next valid instruction appears 2 cycles after JAL on EX.
- Bypass: i_wb_we=1, i_wb_rd=5, i_wb_data=0x1234 in the same cycle as BEQ x5,x6 with x6=0x1234 -> o_btaken=1.
- Write to x0 with 0xDEAD, then ADD x3,x0,x0 -> o_rs1_data=0, o_rs2_data=0.
- Illegal opcode 0x0000007F -> o_illegal pulses one cycle, o_valid=0. Stall held 3 cycles -> IF/ID unchanged and o_valid=0 for 3 cycles.
